// File: rtl/mccpu_ctrl.sv
// mccpu_ctrl: multi-cycle MCCPU control FSM driving ALU op, operand selects and write enables
module mccpu_ctrl (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       mem_we,
  output logic       rf_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMRD = 4'd4, MEMWB = 4'd5, MEMWR = 4'd6,
    EXEC = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9, JUMP = 4'd10, IEXEC = 4'd11, IWB = 4'd12
  } st_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                         OP_BNE = 6'b000101, OP_J = 6'b000010, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010,
                         OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
  localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SUB = 3'd2, AND = 3'd3, OR = 3'd4, SLT = 3'd5, SLTU = 3'd6;
  st_t st;
  logic [2:0] fop, iop;
  assign state = st;
  assign fop = funct == 6'b100000 ? ADD  : funct == 6'b100010 ? SUB :
               funct == 6'b100100 ? AND  : funct == 6'b100101 ? OR  :
               funct == 6'b101010 ? SLT  : funct == 6'b101011 ? SLTU : NOP;
  assign iop = op == OP_ADDI ? ADD : op == OP_SLTI ? SLT : op == OP_ANDI ? AND : op == OP_ORI ? OR : NOP;
  always_ff @(posedge clk)
    if (!rstn) st <= IDLE;
    else
      case (st)
        IDLE:    st <= FETCH;
        FETCH:   st <= DECODE;
        DECODE:  st <= (op == OP_LW || op == OP_SW) ? MEMADR :
                       (op == OP_R && fop != NOP) ? EXEC :
                       (op == OP_BEQ || op == OP_BNE) ? BRANCH :
                       op == OP_J ? JUMP :
                       iop != NOP ? IEXEC : FETCH;
        MEMADR:  st <= op == OP_LW ? MEMRD : MEMWR;
        MEMRD:   st <= MEMWB;
        EXEC:    st <= ALUWB;
        IEXEC:   st <= IWB;
        default: st <= FETCH;
      endcase
  always_comb begin
    alu_op = NOP;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    ext_op = 1'b0;
    ir_we = 1'b0;
    pc_we = 1'b0;
    pc_src = 2'b00;
    mem_we = 1'b0;
    rf_we = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    case (st)
      FETCH: begin
        ir_we = 1'b1;
        alu_src_b = 2'b01;
        alu_op = ADD;
        pc_we = 1'b1;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_op = ADD;
        ext_op = 1'b1;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op = 1'b1;
        alu_op = ADD;
      end
      MEMWB: begin
        rf_we = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: mem_we = 1'b1;
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op = fop;
      end
      ALUWB: begin
        rf_we = 1'b1;
        reg_dst = 1'b1;
      end
      IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op = iop;
        ext_op = op == OP_ADDI || op == OP_SLTI;
      end
      IWB: rf_we = 1'b1;
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = SUB;
        pc_src = 2'b01;
        pc_we = op == OP_BNE ? ~zero : zero;
      end
      JUMP: begin
        pc_src = 2'b10;
        pc_we = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mccpu_ctrl.sv
// tb_mccpu_ctrl: directed and random instruction traces checked against a per-instruction path model
module tb_mccpu_ctrl;
  logic clk, rstn, zero;
  logic [5:0] op, funct;
  logic [2:0] alu_op;
  logic alu_src_a, ext_op, ir_we, pc_we, mem_we, rf_we, reg_dst, mem_to_reg;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] state;
  int tests = 0, fails = 0;
  typedef struct packed {
    logic [3:0] st; logic [2:0] aop; logic sa; logic [1:0] sb; logic ext, ir, pcw;
    logic [1:0] pcs; logic mw, rw, rd, m2r;
  } o_t;
  o_t got;
  mccpu_ctrl dut (
    .clk(clk), .rstn(rstn), .op(op), .funct(funct), .zero(zero), .alu_op(alu_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .mem_we(mem_we), .rf_we(rf_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .state(state)
  );
  assign got = {state, alu_op, alu_src_a, alu_src_b, ext_op, ir_we, pc_we, pc_src, mem_we, rf_we, reg_dst, mem_to_reg};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [5:0] lf [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b101011};
  logic [5:0] ops [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                           6'b000010, 6'b001000, 6'b001010, 6'b001100, 6'b001101};
  function automatic logic [2:0] rop(input logic [5:0] f);
    for (int i = 0; i < 6; i++) if (lf[i] == f) return 3'(i + 1);
    return 3'd0;
  endfunction
  function automatic int path_state(input logic [5:0] o, f, input int k);
    int seq [5];
    int n;
    seq = '{1, 2, 0, 0, 0};
    n = 2;
    case (o)
      6'b100011: begin seq = '{1, 2, 3, 4, 5}; n = 5; end
      6'b101011: begin seq = '{1, 2, 3, 6, 0}; n = 4; end
      6'b000000: if (rop(f) != 0) begin seq = '{1, 2, 7, 8, 0}; n = 4; end
      6'b000100, 6'b000101: begin seq = '{1, 2, 9, 0, 0}; n = 3; end
      6'b000010: begin seq = '{1, 2, 10, 0, 0}; n = 3; end
      6'b001000, 6'b001010, 6'b001100, 6'b001101: begin seq = '{1, 2, 11, 12, 0}; n = 4; end
      default: ;
    endcase
    return k < n ? seq[k] : -1;
  endfunction
  function automatic o_t exp_out(input int s, input logic [5:0] o, f, input logic z);
    o_t e;
    e = '0;
    e.st = 4'(s);
    case (s)
      1: begin e.ir = 1; e.sb = 2'b01; e.aop = 3'd1; e.pcw = 1; end
      2: begin e.sb = 2'b11; e.aop = 3'd1; e.ext = 1; end
      3: begin e.sa = 1; e.sb = 2'b10; e.ext = 1; e.aop = 3'd1; end
      5: begin e.rw = 1; e.m2r = 1; end
      6: e.mw = 1;
      7: begin e.sa = 1; e.aop = rop(f); end
      8: begin e.rw = 1; e.rd = 1; end
      9: begin e.sa = 1; e.aop = 3'd2; e.pcs = 2'b01; e.pcw = (o == 6'b000100) ? z : !z; end
      10: begin e.pcs = 2'b10; e.pcw = 1; end
      11: begin
        e.sa = 1; e.sb = 2'b10;
        e.aop = o == 6'b001000 ? 3'd1 : o == 6'b001010 ? 3'd5 : o == 6'b001100 ? 3'd3 : 3'd4;
        e.ext = o == 6'b001000 || o == 6'b001010;
      end
      12: e.rw = 1;
      default: ;
    endcase
    return e;
  endfunction
  task automatic chk(input string tag, input o_t e);
    tests++;
    assert (got === e) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, e);
    end
  endtask
  task automatic run_instr(input logic [5:0] o, f, input int zm, input int abort);
    op = o;
    funct = f;
    for (int k = 0; path_state(o, f, k) >= 0; k++) begin
      zero = zm == 2 ? 1'($urandom % 2) : zm[0];
      @(negedge clk);
      chk($sformatf("op%b_f%b_k%0d", o, f, k), exp_out(path_state(o, f, k), o, f, zero));
      if (k == abort) begin
        rstn = 1'b0;
        repeat (2) begin
          @(posedge clk); #1;
          @(negedge clk);
          chk("rst_mid", exp_out(0, o, f, zero));
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    logic [5:0] ro, rf;
    rstn = 1'b0; op = '0; funct = '0; zero = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_init", exp_out(0, op, funct, zero));
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    run_instr(6'b100011, 6'b000000, 2, 3);
    run_instr(6'b100011, 6'b010101, 2, -1);
    run_instr(6'b101011, 6'b000000, 2, -1);
    run_instr(6'b000000, 6'b101011, 2, -1);
    run_instr(6'b000000, 6'b000111, 2, -1);
    run_instr(6'b000100, 6'b000000, 1, -1);
    run_instr(6'b000100, 6'b000000, 0, -1);
    run_instr(6'b000101, 6'b000000, 1, -1);
    run_instr(6'b000101, 6'b000000, 0, -1);
    run_instr(6'b001101, 6'b000000, 2, -1);
    run_instr(6'b001000, 6'b000000, 2, -1);
    run_instr(6'b001010, 6'b000000, 2, -1);
    run_instr(6'b001100, 6'b000000, 2, -1);
    run_instr(6'b000010, 6'b000000, 2, -1);
    run_instr(6'b111111, 6'b000000, 2, -1);
    for (int i = 0; i < 6; i++) run_instr(6'b000000, lf[i], 2, -1);
    for (int i = 0; i < 80; i++) begin
      ro = $urandom_range(0, 4) == 0 ? 6'($urandom) : ops[$urandom_range(0, 9)];
      rf = $urandom_range(0, 1) == 0 ? lf[$urandom_range(0, 5)] : 6'($urandom);
      run_instr(ro, rf, 2, (ro == 6'b100011 && $urandom_range(0, 9) == 0) ? 3 : -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
